// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and the
// load/store datapath: one outstanding transfer, stable request, one-cycle responses.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);
    localparam logic [1:0]    SIZE_WORD   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              grant_ls_q, grant_ls_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [TW-1:0]     timeout_cnt_q, timeout_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_err_q, if_err_d;
    logic              ls_ack_q, ls_ack_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              ls_err_q, ls_err_d;

    logic              pick_ls;
    logic [TW-1:0]     timeout_inc;
    logic [DATA_W-1:0] read_data;

    // Load/store has priority unless fetch has lost STARVE_LIMIT times in a row.
    assign pick_ls     = ls_req && !(if_req && (starve_cnt_q == STARVE_MAX));
    assign timeout_inc = timeout_cnt_q + TW'(1);
    assign read_data   = mem_we_q ? '0 : mem_rdata;

    always_comb begin
        state_d       = state_q;
        grant_ls_d    = grant_ls_q;
        starve_cnt_d  = starve_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_size_d    = mem_size_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_ack_d      = 1'b0;
        if_rdata_d    = '0;
        if_err_d      = 1'b0;
        ls_ack_d      = 1'b0;
        ls_rdata_d    = '0;
        ls_err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    state_d    = S_BUSY;
                    grant_ls_d = pick_ls;
                    mem_req_d  = 1'b1;
                    if (pick_ls) begin
                        mem_we_d    = ls_we;
                        mem_size_d  = ls_size;
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_size_d  = SIZE_WORD;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                    if (if_req && !pick_ls) begin
                        starve_cnt_d = '0;
                    end else if (if_req && (starve_cnt_q != STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end
            end

            S_BUSY: begin
                if (mem_ready) begin
                    state_d       = S_RESP;
                    mem_req_d     = 1'b0;
                    timeout_cnt_d = '0;
                    if (grant_ls_q) begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = read_data;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = read_data;
                    end
                end else if (timeout_inc == TIMEOUT_MAX) begin
                    // Abort: memory never answered, report an error with zero data.
                    state_d       = S_RESP;
                    mem_req_d     = 1'b0;
                    timeout_cnt_d = '0;
                    if (grant_ls_q) begin
                        ls_ack_d = 1'b1;
                        ls_err_d = 1'b1;
                    end else begin
                        if_ack_d = 1'b1;
                        if_err_d = 1'b1;
                    end
                end else begin
                    timeout_cnt_d = timeout_inc;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            grant_ls_q    <= 1'b0;
            starve_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_size_q    <= 2'b00;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_ack_q      <= 1'b0;
            if_rdata_q    <= '0;
            if_err_q      <= 1'b0;
            ls_ack_q      <= 1'b0;
            ls_rdata_q    <= '0;
            ls_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_ls_q    <= grant_ls_d;
            starve_cnt_q  <= starve_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_size_q    <= mem_size_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_ack_q      <= if_ack_d;
            if_rdata_q    <= if_rdata_d;
            if_err_q      <= if_err_d;
            ls_ack_q      <= ls_ack_d;
            ls_rdata_q    <= ls_rdata_d;
            ls_err_q      <= ls_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign ls_ack    = ls_ack_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_err    = ls_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transfers scored against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, ls_req, ls_we, mem_ready;
    logic [AW-1:0] if_addr, ls_addr;
    logic [1:0]    ls_size;
    logic [DW-1:0] ls_wdata, mem_rdata;
    logic          if_ack, if_err, ls_ack, ls_err, mem_req, mem_we, busy;
    logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;
    int m_starve = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference arbitration: returns 1 when load/store wins, tracks fetch losses.
    function automatic bit model_arb(input bit ifr, input bit lsr);
        bit w;
        if (ifr && lsr) w = (m_starve != SL);
        else            w = lsr;
        if (ifr && !w)                     m_starve = 0;
        else if (ifr && w && m_starve < SL) m_starve = m_starve + 1;
        return w;
    endfunction

    // One complete transfer starting from IDLE; returns at the IDLE cycle after RESP.
    task automatic xfer(input string nm, input bit ifr, input bit lsr, input bit we,
                        input logic [1:0] sz, input logic [31:0] ia, input logic [31:0] la,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
        bit wl;
        logic [31:0] ea, erd;
        logic ewe;
        logic [1:0] esz;
        wl  = model_arb(ifr, lsr);
        ea  = wl ? la : ia;
        ewe = wl ? we : 1'b0;
        esz = wl ? sz : 2'b10;
        erd = (wl && we) ? 32'h0 : rd;
        if_req = ifr; if_addr = ia;
        ls_req = lsr; ls_we = we; ls_size = sz; ls_addr = la; ls_wdata = wd;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, mem_we, mem_size} !== {1'b1, ea, ewe, esz}) begin
            errors++;
            $display("FAIL %s mem_issue got req=%b addr=%h we=%b size=%b want req=1 addr=%h we=%b size=%b",
                     nm, mem_req, mem_addr, mem_we, mem_size, ea, ewe, esz);
        end
        if (wl) begin
            checks++;
            if (mem_wdata !== wd) begin
                errors++;
                $display("FAIL %s mem_wdata got %h want %h", nm, mem_wdata, wd);
            end
        end
        for (int i = 0; i < waits; i++) begin
            mem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if ({mem_req, mem_addr, mem_we, mem_size, busy, if_ack, ls_ack} !== {1'b1, ea, ewe, esz, 1'b1, 2'b00}) begin
                errors++;
                $display("FAIL %s wait%0d_stable got req=%b addr=%h we=%b size=%b busy=%b acks=%b%b want addr=%h",
                         nm, i, mem_req, mem_addr, mem_we, mem_size, busy, if_ack, ls_ack, ea);
            end
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        checks++;
        if ({if_ack, ls_ack} !== {~wl, wl}) begin
            errors++;
            $display("FAIL %s ack got if=%b ls=%b want if=%b ls=%b", nm, if_ack, ls_ack, ~wl, wl);
        end
        checks++;
        if ({if_rdata, ls_rdata} !== (wl ? {32'h0, erd} : {erd, 32'h0})) begin
            errors++;
            $display("FAIL %s rdata got if=%h ls=%h want %h on %s", nm, if_rdata, ls_rdata, erd, wl ? "ls" : "if");
        end
        checks++;
        if ({if_err, ls_err, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL %s err_req got if_err=%b ls_err=%b mem_req=%b want 0", nm, if_err, ls_err, mem_req);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_ack, ls_ack, if_err, ls_err, if_rdata, ls_rdata, busy} !== '0) begin
            errors++;
            $display("FAIL %s after_resp got acks=%b%b errs=%b%b rdata=%h/%h busy=%b want all 0",
                     nm, if_ack, ls_ack, if_err, ls_err, if_rdata, ls_rdata, busy);
        end
    endtask

    task automatic test_reset();
        if_req = 1'b1;
        if_addr = 32'h44;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata, if_ack, if_rdata, if_err,
             ls_ack, ls_rdata, ls_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b addr=%h busy=%b acks=%b%b want all 0",
                     mem_req, mem_addr, busy, if_ack, ls_ack);
        end
        if_req = 1'b0;
        rst_n = 1'b1;
        m_starve = 0;
        @(negedge clk);
        checks++;
        if ({busy, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%b mem_req=%b want 0", busy, mem_req);
        end
    endtask

    task automatic test_fetch_basic();
        xfer("fetch_basic", 1'b1, 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 32'h0, 32'hE3A00001, 0);
    endtask

    task automatic test_starvation();
        bit exp_ls, got_ls;
        bit seq [10];
        int n;
        logic [31:0] rd;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200; ls_wdata = 32'h0;
        for (int g = 0; g < 10; g++) begin
            exp_ls = model_arb(1'b1, 1'b1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (mem_req !== 1'b1 && n < 6);
            checks++;
            if (mem_req !== 1'b1) begin
                errors++;
                $display("FAIL starve_grant%0d mem_req got %b want 1 within 6 cycles", g, mem_req);
            end
            got_ls = (mem_addr == 32'h200);
            seq[g] = got_ls;
            checks++;
            if (got_ls !== exp_ls) begin
                errors++;
                $display("FAIL starve_winner%0d got ls=%b want ls=%b", g, got_ls, exp_ls);
            end
            rd = $urandom;
            mem_ready = 1'b1;
            mem_rdata = rd;
            @(negedge clk);
            mem_ready = 1'b0;
            checks++;
            if ({if_ack, ls_ack, exp_ls ? ls_rdata : if_rdata} !== {~exp_ls, exp_ls, rd}) begin
                errors++;
                $display("FAIL starve_ack%0d got acks=%b%b rdata=%h/%h want ls=%b data=%h",
                         g, if_ack, ls_ack, if_rdata, ls_rdata, exp_ls, rd);
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]} !== 6'b111101) begin
            errors++;
            $display("FAIL starve_sequence got %b%b%b%b%b%b want 111101",
                     seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]);
        end
    endtask

    task automatic test_store_byte();
        xfer("store_byte", 1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h203, 32'hAB, 32'h5A5A5A5A, 3);
    endtask

    task automatic test_timeout();
        int n;
        void'(model_arb(1'b1, 1'b0));
        if_req = 1'b1; if_addr = 32'h500;
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        n = 0;
        @(negedge clk);
        while (mem_req === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != TO) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want %0d", n, TO);
        end
        checks++;
        if ({if_ack, if_err, if_rdata, ls_ack} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_resp got if_ack=%b if_err=%b if_rdata=%h ls_ack=%b want 1 1 0 0",
                     if_ack, if_err, if_rdata, ls_ack);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_ack, if_err} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_err_drop got ack=%b err=%b want 0", if_ack, if_err);
        end
        xfer("after_timeout", 1'b1, 1'b0, 1'b0, 2'b10, 32'h504, 32'h0, 32'h0, 32'h12345678, 0);
    endtask

    task automatic test_async_reset();
        void'(model_arb(1'b0, 1'b1));
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h600; ls_wdata = 32'h0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL areset_busy mem_req got %b want 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, busy, if_ack, ls_ack} !== '0) begin
            errors++;
            $display("FAIL areset_outputs got req=%b addr=%h busy=%b acks=%b%b want all 0",
                     mem_req, mem_addr, busy, if_ack, ls_ack);
        end
        m_starve = 0;
        ls_req = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({if_ack, ls_ack, busy, mem_req} !== 4'b0000) begin
                errors++;
                $display("FAIL areset_no_ack%0d got acks=%b%b busy=%b req=%b want 0",
                         i, if_ack, ls_ack, busy, mem_req);
            end
        end
        mem_ready = 1'b0;
        xfer("after_areset", 1'b1, 1'b0, 1'b0, 2'b10, 32'h700, 32'h0, 32'h0, 32'hCAFEF00D, 1);
    endtask

    task automatic test_resp_new_req();
        logic [31:0] rd;
        void'(model_arb(1'b1, 1'b0));
        if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h11112222;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++;
        if ({if_ack, if_rdata} !== {1'b1, 32'h11112222}) begin
            errors++;
            $display("FAIL respnew_if_ack got ack=%b data=%h want 1 11112222", if_ack, if_rdata);
        end
        void'(model_arb(1'b0, 1'b1));
        if_req = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h402; ls_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL respnew_idle got mem_req=%b busy=%b want 0 0", mem_req, busy);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, mem_size} !== {1'b1, 32'h402, 2'b01}) begin
            errors++;
            $display("FAIL respnew_issue got req=%b addr=%h size=%b want 1 402 01", mem_req, mem_addr, mem_size);
        end
        rd = $urandom;
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++;
        if ({ls_ack, ls_rdata, if_ack} !== {1'b1, rd, 1'b0}) begin
            errors++;
            $display("FAIL respnew_ls_ack got ls_ack=%b data=%h if_ack=%b want 1 %h 0", ls_ack, ls_rdata, if_ack, rd);
        end
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int r;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(1, 3);
            xfer("random", r[0], r[1], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                 $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                checks++;
                if ({busy, if_ack, ls_ack, mem_req} !== 4'b0000) begin
                    errors++;
                    $display("FAIL random_stray_ready got busy=%b acks=%b%b req=%b want 0",
                             busy, if_ack, ls_ack, mem_req);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        test_reset();
        test_fetch_basic();
        test_starvation();
        test_store_byte();
        test_timeout();
        test_async_reset();
        test_resp_new_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
